// File: rtl/rom3to8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom3to8_pkg
//  Description : Shared constants, word type and content tables for the
//                8 x 8-bit synchronous lookup ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom3to8_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] rom_word_t;

    // Content selectors for INIT_MODE
    localparam int C_MODE_ONEHOT = 0;
    localparam int C_MODE_THERMO = 1;

    // Entry i = 1 << i
    localparam rom_word_t ONEHOT_TABLE [0:DEPTH-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    // Entry i = (2 << i) - 1
    localparam rom_word_t THERMO_TABLE [0:DEPTH-1] = '{
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF
    };

    // Full-case lookup; out-of-range or unknown addresses read as zero.
    function automatic rom_word_t rom_lookup(input logic mode, input logic [ADDR_W-1:0] addr);
        rom_word_t w_word;
        w_word = 8'h00;
        case (addr)
            3'd0:    w_word = mode ? THERMO_TABLE[0] : ONEHOT_TABLE[0];
            3'd1:    w_word = mode ? THERMO_TABLE[1] : ONEHOT_TABLE[1];
            3'd2:    w_word = mode ? THERMO_TABLE[2] : ONEHOT_TABLE[2];
            3'd3:    w_word = mode ? THERMO_TABLE[3] : ONEHOT_TABLE[3];
            3'd4:    w_word = mode ? THERMO_TABLE[4] : ONEHOT_TABLE[4];
            3'd5:    w_word = mode ? THERMO_TABLE[5] : ONEHOT_TABLE[5];
            3'd6:    w_word = mode ? THERMO_TABLE[6] : ONEHOT_TABLE[6];
            3'd7:    w_word = mode ? THERMO_TABLE[7] : ONEHOT_TABLE[7];
            default: w_word = 8'h00;
        endcase
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom3to8_table.sv
`default_nettype none
// ============================================================================
//  Module      : rom3to8_table
//  Description : Purely combinational address -> word lookup. The content
//                set (one-hot or thermometer) is fixed by INIT_MODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom3to8_table
    import rom3to8_pkg::*;
#(
    parameter int INIT_MODE = 0
) (
    input  logic [ADDR_W-1:0] i_address,
    output rom_word_t         o_word
);

    // Any INIT_MODE other than 1 falls back to the one-hot table.
    localparam logic C_MODE = (INIT_MODE == C_MODE_THERMO) ? 1'b1 : 1'b0;

    // Constant-mode table read; the mode term folds away at elaboration.
    always_comb begin
        o_word = rom_lookup(C_MODE, i_address);
    end

endmodule
`default_nettype wire

// File: rtl/rom3to8_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rom3to8_sync
//  Description : Synchronous 8 x 8-bit lookup ROM with chip select. Output
//                word, valid flag and even-parity bit are registered with a
//                single cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom3to8_sync
    import rom3to8_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              sel,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              parity
);

    rom_word_t         w_table_word;
    logic [DATA_W-1:0] w_data_d;
    logic              w_valid_d;
    logic              w_parity_d;
    logic [DATA_W-1:0] r_data_q;
    logic              r_valid_q;
    logic              r_parity_q;

    rom3to8_table #(
        .INIT_MODE (INIT_MODE)
    ) u_table (
        .i_address (address),
        .o_word    (w_table_word)
    );

    // Select gating: a deselected read forces zero so address X/Z never reaches data.
    always_comb begin
        w_data_d   = '0;
        w_valid_d  = 1'b0;
        if (sel) begin
            w_data_d  = w_table_word;
            w_valid_d = 1'b1;
        end
        w_parity_d = ^w_data_d;
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            r_parity_q <= 1'b0;
        end else begin
            r_data_q   <= w_data_d;
            r_valid_q  <= w_valid_d;
            r_parity_q <= w_parity_d;
        end
    end

    assign data       = r_data_q;
    assign data_valid = r_valid_q;
    assign parity     = r_parity_q;

endmodule
`default_nettype wire

// File: tb/tb_rom3to8_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom3to8_sync
//  Description : Self-checking bench for rom3to8_sync; one instance per
//                content mode, both driven by the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom3to8_sync;

    logic       clk;
    logic       rst_n;
    logic [2:0] address;
    logic       sel;
    logic [7:0] data_oh, data_th;
    logic       valid_oh, valid_th;
    logic       parity_oh, parity_th;

    int total;
    int bad;

    rom3to8_sync #(.DATA_W(8), .ADDR_W(3), .INIT_MODE(0)) u_dut_onehot (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .sel        (sel),
        .data       (data_oh),
        .data_valid (valid_oh),
        .parity     (parity_oh)
    );

    rom3to8_sync #(.DATA_W(8), .ADDR_W(3), .INIT_MODE(1)) u_dut_thermo (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .sel        (sel),
        .data       (data_th),
        .data_valid (valid_th),
        .parity     (parity_th)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: table word from its arithmetic definition.
    function automatic logic [7:0] model_word(input int mode, input logic s, input logic [2:0] a);
        int v;
        if (!s) return 8'h00;
        if (mode == 1) v = (2 << int'(a)) - 1;
        else           v = 1 << int'(a);
        return v[7:0];
    endfunction

    function automatic logic model_parity(input logic [7:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic s, input logic [2:0] a);
        logic [7:0] e_oh, e_th;
        e_oh = model_word(0, s, a);
        e_th = model_word(1, s, a);
        check_val({tag, " oh data"},   32'(data_oh),   32'(e_oh));
        check_val({tag, " oh valid"},  32'(valid_oh),  32'(s));
        check_val({tag, " oh parity"}, 32'(parity_oh), 32'(model_parity(e_oh)));
        check_val({tag, " th data"},   32'(data_th),   32'(e_th));
        check_val({tag, " th valid"},  32'(valid_th),  32'(s));
        check_val({tag, " th parity"}, 32'(parity_th), 32'(model_parity(e_th)));
    endtask

    task automatic check_zero(input string tag);
        check_all(tag, 1'b0, 3'd0);
    endtask

    // Drive at negedge, capture on posedge, sample 1 time unit later.
    task automatic step(input string tag, input logic s, input logic [2:0] a);
        @(negedge clk);
        sel     = s;
        address = a;
        @(posedge clk);
        #1;
        check_all(tag, s, a);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        sel     = 1'b1;
        address = 3'd5;

        // Held in reset across edges with an active read request
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Deselect sweep, including an unknown address
        for (int i = 0; i < 8; i++) step("deselect", 1'b0, 3'(i));
        step("deselect addrX", 1'b0, 3'bxxx);

        // Full sweep for both tables
        for (int i = 0; i < 8; i++) step("sweep", 1'b1, 3'(i));

        // Select toggling on a fixed address
        step("toggle1", 1'b1, 3'd3);
        step("toggle0", 1'b0, 3'd3);
        step("toggle1b", 1'b1, 3'd3);

        // Address change mid-cycle does not reach data until the next edge
        step("addr6", 1'b1, 3'd6);
        @(negedge clk);
        address = 3'd7;
        #1;
        check_all("addr7 pre-edge", 1'b1, 3'd6);
        @(posedge clk);
        #1;
        check_all("addr7 post-edge", 1'b1, 3'd7);

        // Asynchronous reset mid-read
        step("pre-reset", 1'b1, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(posedge clk);
        #1;
        check_zero("reset across edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("after release");
        @(posedge clk);
        #1;
        check_all("first read after reset", 1'b1, 3'd5);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step("random", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
